aes_encrypt_iter: RTL and testbench
===================================

AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

Interface
REQ-001 SHALL have parameter N, default 1, key-size selector: Nk = 2N+2 words, Nr = 2N+8 rounds; legal values are 1 (AES-128), 2 (AES-192) and 3 (AES-256).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit, plaintext and key present.
REQ-005 SHALL have port in_ready, output, 1 bit, core can accept a block.
REQ-006 SHALL have port in_data, input, 128 bits, plaintext; FIPS-197 byte 0 in [127:120].
REQ-007 SHALL have port key, input, (2N+2)*32 bits, cipher key; key byte 0 in the MSBs.
REQ-008 SHALL have port out_valid, output, 1 bit, ciphertext available.
REQ-009 SHALL have port out_ready, input, 1 bit, consumer takes the ciphertext.
REQ-010 SHALL have port out_data, output, 128 bits, ciphertext, same byte order as in_data.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-012 in_ready SHALL equal 1 exactly when state is IDLE; in_valid outside IDLE SHALL be ignored.
REQ-013 On accept (IDLE, in_valid=1) the core SHALL register key, load state <= in_data XOR round key 0, set round counter to 1 and enter BUSY.
REQ-014 In BUSY, each cycle SHALL apply one round to state: SubBytes, ShiftRows, MixColumns, then XOR round key r; MixColumns SHALL be omitted when r = Nr.
REQ-015 The round counter SHALL be 4 bits; after round Nr the core SHALL enter DONE, never wrapping past Nr.
REQ-016 out_valid SHALL be 1 exactly in DONE; out_data SHALL hold the ciphertext stable for as long as DONE lasts.
REQ-017 Latency SHALL be exactly Nr+1 cycles from the accepting edge to the first cycle with out_valid=1 (11/13/15 for N=1/2/3).
REQ-018 DONE with out_ready=1 SHALL return to IDLE on that edge; DONE with out_ready=0 SHALL hold (backpressure, no data loss).
REQ-019 A new block SHALL not be accepted in the same cycle the result is consumed; peak throughput is one block per Nr+2 cycles.
REQ-020 Round keys SHALL be derived only from the registered key; changing the key port during BUSY/DONE SHALL not affect the result.
REQ-021 out_data SHALL retain the last ciphertext after the DONE->IDLE transition until the next result overwrites it.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, round counter 0, state register 0, key register 0, out_valid 0, out_data 0, in_ready 1.
REQ-023 Reset during BUSY or DONE SHALL abort the block without producing a result; the first post-reset accept SHALL behave exactly as if from power-up.

Structure
REQ-024 A shared package SHALL hold the S-box table, the xtime/GF(2^8) multiply, the SubBytes/ShiftRows/MixColumns functions and the Nk/Nr constants as functions of N.
REQ-025 Key schedule SHALL be a combinational sub-module aes_key_expand (parameter N), registered key in, 128*(Nr+1)-bit round-key vector out, round key r at bits [128*(Nr+1-r)-1 -: 128].
REQ-026 The round-key select SHALL be a mux indexed by the round counter; no other sub-modules.

Verification
REQ-027 N=1, key 000102030405060708090a0b0c0d0e0f, in_data 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 cycles after accept.
REQ-028 N=2, key 000102...1617, same plaintext -> dda97ca4864cdfe06eaf70a0ec0d7191 after 13 cycles; N=3, key 000102...1e1f -> 8ea2b7ca516745bfeafc49904b496089 after 15 cycles.
REQ-029 Hold out_ready=0 for 20 cycles in DONE -> out_valid stays 1, out_data stable, in_ready 0; then out_ready=1 -> IDLE next cycle.
REQ-030 Toggle in_valid, in_data and key randomly during BUSY -> ignored, in_ready 0, result equals the vector for the accepted inputs.
REQ-031 Assert rst_n=0 at round 5 -> out_valid never rises for that block; a fresh FIPS-197 vector accepted afterwards encrypts correctly.
REQ-032 Back-to-back stream of 100 random blocks with out_ready=1, compared against a reference model -> all match, one accept per Nr+2 cycles.

Source files
------------

// File: rtl/aes_encrypt_iter_pkg.sv
// Shared AES-128/192/256 primitives: S-box, GF(2^8) arithmetic, round
// transforms and key-size constants. State byte 0 sits in bits [127:120],
// column-major as in FIPS-197.
package aes_encrypt_iter_pkg;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic int key_nk(input int n);
    return 2 * n + 2;
  endfunction

  function automatic int key_nr(input int n);
    return 2 * n + 8;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add over the AES polynomial
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Round constant for key-schedule iteration j (j >= 1)
  function automatic logic [7:0] rcon(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i < j; i++) r = xtime(r);
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Row r rotates left by r columns
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_encrypt_iter_key_expand.sv
// Combinational AES key schedule. Round key r occupies
// round_keys[128*(Nr+1-r)-1 -: 128]; round key 0 is the top 128 bits.
module aes_key_expand
  import aes_encrypt_iter_pkg::*;
#(
  parameter int N = 1
) (
  input  logic [32*(2*N+2)-1:0]     key,
  output logic [128*(2*N+9)-1:0]    round_keys
);

  localparam int NK   = key_nk(N);
  localparam int NR   = key_nr(N);
  localparam int TOTW = 4 * (NR + 1);

  logic [31:0] w [0:TOTW-1];

  // Expand the cipher key word by word, then pack words MSB-first
  always_comb begin
    logic [31:0] tmp;
    tmp        = '0;
    round_keys = '0;
    for (int i = 0; i < TOTW; i++) begin
      if (i < NK) begin
        w[i] = key[32*(NK-i)-1 -: 32];
      end else begin
        tmp = w[i-1];
        if (i % NK == 0)
          tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon(i / NK), 24'h000000};
        else if (NK > 6 && i % NK == 4)
          tmp = sub_word(tmp);
        w[i] = w[i-NK] ^ tmp;
      end
    end
    for (int i = 0; i < TOTW; i++) round_keys[32*(TOTW-i)-1 -: 32] = w[i];
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryptor: one round per clock, valid/ready on both sides.
// Key is captured on accept; all later round keys come from that copy.
module aes_encrypt_iter
  import aes_encrypt_iter_pkg::*;
#(
  parameter int N = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [127:0]            in_data,
  input  logic [32*(2*N+2)-1:0]   key,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [127:0]            out_data
);

  localparam int NK = key_nk(N);
  localparam int NR = key_nr(N);
  localparam int KW = 32 * NK;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            fsm;
  logic [3:0]            rnd;
  logic [127:0]          st;
  logic [KW-1:0]         key_r;
  logic [128*(NR+1)-1:0] rk_vec;
  logic [127:0]          rk_arr [0:15];
  logic [127:0]          rk_sel;
  logic [127:0]          sr;
  logic [127:0]          round_out;

  aes_key_expand #(.N(N)) u_kexp (
    .key        (key_r),
    .round_keys (rk_vec)
  );

  // Round-key table indexed by the round counter; unused slots read zero
  for (genvar r = 0; r < 16; r++) begin : g_rk
    if (r <= NR) begin : g_used
      assign rk_arr[r] = rk_vec[128*(NR+1-r)-1 -: 128];
    end else begin : g_unused
      assign rk_arr[r] = '0;
    end
  end

  assign rk_sel = rk_arr[rnd];

  // One cipher round; the final round skips MixColumns
  always_comb begin
    sr        = shift_rows(sub_bytes(st));
    round_out = ((rnd == 4'(NR)) ? sr : mix_columns(sr)) ^ rk_sel;
  end

  assign in_ready  = (fsm == IDLE);
  assign out_valid = (fsm == DONE);

  // Control FSM with state, key and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= IDLE;
      rnd      <= '0;
      st       <= '0;
      key_r    <= '0;
      out_data <= '0;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          key_r <= key;
          st    <= in_data ^ key[KW-1 -: 128];
          rnd   <= 4'd1;
          fsm   <= BUSY;
        end
        BUSY: begin
          st <= round_out;
          if (rnd == 4'(NR)) begin
            out_data <= round_out;
            fsm      <= DONE;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        DONE: if (out_ready) fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: three instances (AES-128/192/256) against
// FIPS-197 vectors and a byte-array AES reference model.
module tb_aes_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iv   [3];
  logic         ir   [3];
  logic [127:0] id   [3];
  logic [255:0] ky   [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [127:0] od   [3];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sb_t [256];

  always #5 clk = ~clk;

  aes_encrypt_iter #(.N(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id[0]), .key(ky[0][255:128]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_data(od[0]));
  aes_encrypt_iter #(.N(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id[1]), .key(ky[1][255:64]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_data(od[1]));
  aes_encrypt_iter #(.N(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(id[2]), .key(ky[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .out_data(od[2]));

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_enc(input int n, input logic [255:0] k, input logic [127:0] pt);
    int nk, nr;
    logic [7:0] w [60][4];
    logic [7:0] t [4];
    logic [7:0] s [16];
    logic [7:0] u [16];
    logic [7:0] rc, t0;
    logic [127:0] res;
    nk = 2 * n + 2;
    nr = 2 * n + 8;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        for (int j = 0; j < 4; j++) w[i][j] = k[255-32*i-8*j -: 8];
      end else begin
        for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
        if (i % nk == 0) begin
          t0 = t[0];
          t[0] = sb_t[t[1]] ^ rc; t[1] = sb_t[t[2]]; t[2] = sb_t[t[3]]; t[3] = sb_t[t0];
          rc = m_mul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          for (int j = 0; j < 4; j++) t[j] = sb_t[t[j]];
        end
        for (int j = 0; j < 4; j++) w[i][j] = w[i-nk][j] ^ t[j];
      end
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][i%4];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) u[4*c+rw] = s[4*((c+rw)%4)+rw];
      for (int c = 0; c < 4; c++) begin
        if (r != nr) begin
          s[4*c+0] = m_mul(u[4*c], 2) ^ m_mul(u[4*c+1], 3) ^ u[4*c+2] ^ u[4*c+3];
          s[4*c+1] = u[4*c] ^ m_mul(u[4*c+1], 2) ^ m_mul(u[4*c+2], 3) ^ u[4*c+3];
          s[4*c+2] = u[4*c] ^ u[4*c+1] ^ m_mul(u[4*c+2], 2) ^ m_mul(u[4*c+3], 3);
          s[4*c+3] = m_mul(u[4*c], 3) ^ u[4*c+1] ^ u[4*c+2] ^ m_mul(u[4*c+3], 2);
        end else begin
          for (int rw = 0; rw < 4; rw++) s[4*c+rw] = u[4*c+rw];
        end
        for (int rw = 0; rw < 4; rw++) s[4*c+rw] ^= w[4*r+c][rw];
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [255:0] rnd_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || od[k] !== 128'h0) begin
        n_bad++;
        $display("FAIL reset[%0d]: got ready=%b valid=%b data=%h want 1 0 0", k, ir[k], ov[k], od[k]);
      end
    end
  endtask

  // Accept one block on instance k, check latency, result and retention
  task automatic run_vector(input int k, input logic [255:0] kk, input logic [127:0] pt,
                            input logic [127:0] exp, input string nm);
    int cyc, nr;
    nr = 10 + 2 * k;
    @(negedge clk);
    iv[k] = 1'b1; id[k] = pt; ky[k] = kk;
    n_cmp++;
    if (ir[k] !== 1'b1) begin n_bad++; $display("FAIL %s_ready: got %b want 1", nm, ir[k]); end
    @(negedge clk);
    iv[k] = 1'b0;
    cyc = 1;
    while (ov[k] !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    n_cmp++;
    if (cyc != nr + 1) begin n_bad++; $display("FAIL %s_latency: got %0d want %0d", nm, cyc, nr + 1); end
    n_cmp++;
    if (od[k] !== exp) begin n_bad++; $display("FAIL %s_data: got %h want %h", nm, od[k], exp); end
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
    n_cmp++;
    if (ov[k] !== 1'b0 || ir[k] !== 1'b1 || od[k] !== exp) begin
      n_bad++;
      $display("FAIL %s_retain: got valid=%b ready=%b data=%h want 0 1 %h", nm, ov[k], ir[k], od[k], exp);
    end
  endtask

  task automatic test_fips();
    run_vector(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
               128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "fips128");
    run_vector(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
               128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, "fips192");
    run_vector(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
               128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, "fips256");
  endtask

  task automatic test_backpressure();
    logic [255:0] kk;
    logic [127:0] pt, exp;
    int cyc;
    kk = rnd_key(); pt = rnd_blk(); exp = ref_enc(1, kk, pt);
    @(negedge clk);
    iv[0] = 1'b1; id[0] = pt; ky[0] = kk;
    @(negedge clk);
    iv[0] = 1'b0;
    cyc = 0;
    while (ov[0] !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || od[0] !== exp) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got valid=%b ready=%b data=%h want 1 0 %h", i, ov[0], ir[0], od[0], exp);
      end
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    n_cmp++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_bad++; $display("FAIL bp_release: got valid=%b ready=%b want 0 1", ov[0], ir[0]);
    end
  endtask

  // Inputs churn while busy; result must reflect the accepted block only
  task automatic test_busy_ignore();
    logic [255:0] kk;
    logic [127:0] pt, exp;
    int cyc;
    kk = rnd_key(); pt = rnd_blk(); exp = ref_enc(2, kk, pt);
    @(negedge clk);
    iv[1] = 1'b1; id[1] = pt; ky[1] = kk;
    @(negedge clk);
    cyc = 0;
    while (ov[1] !== 1'b1 && cyc < 40) begin
      n_cmp++;
      if (ir[1] !== 1'b0) begin n_bad++; $display("FAIL busy_ready: got %b want 0", ir[1]); end
      iv[1] = 1'($urandom_range(0, 1)); id[1] = rnd_blk(); ky[1] = rnd_key();
      @(negedge clk);
      cyc++;
    end
    iv[1] = 1'b0;
    n_cmp++;
    if (od[1] !== exp || ov[1] !== 1'b1) begin
      n_bad++; $display("FAIL busy_data: got %h valid=%b want %h", od[1], ov[1], exp);
    end
    ordy[1] = 1'b1;
    @(negedge clk);
    ordy[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [127:0] pt;
    bit seen;
    pt = rnd_blk();
    @(negedge clk);
    iv[0] = 1'b1; id[0] = pt; ky[0] = rnd_key();
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || od[0] !== 128'h0) begin
      n_bad++; $display("FAIL rst_mid: got valid=%b ready=%b data=%h want 0 1 0", ov[0], ir[0], od[0]);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (ov[0] !== 1'b0) seen = 1'b1; end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL rst_abort: got valid rise want none"); end
    run_vector(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
               128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "post_rst");
  endtask

  // 100 random blocks with the consumer always ready
  task automatic test_back_to_back();
    logic [127:0] q [$];
    logic [127:0] exp;
    int acc, got, cyc, last;
    bit pend;
    acc = 0; got = 0; cyc = 0; last = 0; pend = 1'b0;
    ordy[0] = 1'b1;
    iv[0] = 1'b1; id[0] = rnd_blk(); ky[0] = rnd_key();
    while (got < 100 && cyc < 5000) begin
      if (ov[0] === 1'b1) begin
        exp = (q.size() > 0) ? q.pop_front() : 128'hx;
        n_cmp++;
        if (od[0] !== exp) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", got, od[0], exp); end
        got++;
      end
      if (ir[0] === 1'b1 && acc < 100) begin
        q.push_back(ref_enc(1, ky[0], id[0]));
        if (acc > 0) begin
          n_cmp++;
          if (cyc - last != 12) begin n_bad++; $display("FAIL b2b_rate: got %0d want 12", cyc - last); end
        end
        last = cyc;
        acc++;
        pend = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (pend) begin
        pend = 1'b0;
        if (acc < 100) begin id[0] = rnd_blk(); ky[0] = rnd_key(); end
        else iv[0] = 1'b0;
      end
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b0;
    n_cmp++;
    if (got != 100) begin n_bad++; $display("FAIL b2b_count: got %0d want 100", got); end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; id[k] = '0; ky[k] = '0; ordy[k] = 1'b0;
    end
    build_sbox();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_fips();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
